// File: rtl/ir_motion_seq.sv
// ir_motion_seq: steering sequencer for the line-following cart.
// Scans three IR emitter/receiver pairs through a shared A2D and turns
// the weighted right-minus-left error into left/right motor duties.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   go                motion enable; low forces IDLE with zero duties
//   cnv_done          one-cycle A2D completion pulse, a2d_res valid
//   a2d_res[11:0]     unsigned conversion result
//   strt_cnv          one-cycle conversion request
//   chnnl[2:0]        A2D channel select
//   IR_*_en           emitter enables for inner/mid/outer pair
//   lft_duty[10:0]    left motor duty
//   rht_duty[10:0]    right motor duty
//   cycle_done        pulses on the cycle new duties first appear

module ir_motion_seq #(
    parameter int SETTLE_CYC = 4096,
    parameter int BASE_DUTY  = 1024,
    parameter int GAIN_SHFT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        cnv_done,
    input  logic [11:0] a2d_res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic        IR_in_en,
    output logic        IR_mid_en,
    output logic        IR_out_en,
    output logic [10:0] lft_duty,
    output logic [10:0] rht_duty,
    output logic        cycle_done
);

    typedef enum logic [2:0] {
        IDLE, SETTLE, CNV_R, WAIT_R, CNV_L, WAIT_L, NEXT, CALC
    } state_t;

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
    localparam logic signed [13:0] BASE14 = 14'(BASE_DUTY);

    state_t             state_q, state_d;
    logic [1:0]         pair_q, pair_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic signed [15:0] accum_q, accum_d;
    logic [11:0]        right_q, right_d;
    logic               strt_q, strt_d;
    logic [2:0]         chnnl_q, chnnl_d;
    logic [2:0]         en_q, en_d;
    logic [10:0]        lft_q, lft_d;
    logic [10:0]        rht_q, rht_d;
    logic               done_q, done_d;

    logic signed [12:0] diff;
    logic signed [15:0] wdiff;
    logic signed [11:0] sat;
    logic signed [11:0] err;
    logic signed [13:0] err_x;
    logic signed [13:0] lsum;
    logic signed [13:0] rsum;
    logic [10:0]        lft_calc;
    logic [10:0]        rht_calc;

    function automatic logic [2:0] rch(input logic [1:0] p);
        unique case (p)
            2'd0:    rch = 3'd1;
            2'd1:    rch = 3'd4;
            default: rch = 3'd3;
        endcase
    endfunction

    function automatic logic [2:0] lch(input logic [1:0] p);
        unique case (p)
            2'd0:    lch = 3'd0;
            2'd1:    lch = 3'd2;
            default: lch = 3'd7;
        endcase
    endfunction

    // Weighted error term and the duty computation used in CALC.
    always_comb begin
        diff  = $signed({1'b0, right_q}) - $signed({1'b0, a2d_res});
        wdiff = {{3{diff[12]}}, diff} << pair_q;
        if (accum_q > 16'sd2047) begin
            sat = 12'sd2047;
        end else if (accum_q < -16'sd2048) begin
            sat = 12'sh800;
        end else begin
            sat = accum_q[11:0];
        end
        err   = sat >>> GAIN_SHFT;
        err_x = {{2{err[11]}}, err};
        lsum  = BASE14 + err_x;
        rsum  = BASE14 - err_x;
        if (lsum < 14'sd0) begin
            lft_calc = 11'd0;
        end else if (lsum > 14'sd2047) begin
            lft_calc = 11'd2047;
        end else begin
            lft_calc = lsum[10:0];
        end
        if (rsum < 14'sd0) begin
            rht_calc = 11'd0;
        end else if (rsum > 14'sd2047) begin
            rht_calc = 11'd2047;
        end else begin
            rht_calc = rsum[10:0];
        end
    end

    always_comb begin
        state_d = state_q;
        pair_d  = pair_q;
        cnt_d   = cnt_q;
        accum_d = accum_q;
        right_d = right_q;
        lft_d   = lft_q;
        rht_d   = rht_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = SETTLE;
                pair_d  = 2'd0;
                accum_d = '0;
                cnt_d   = '0;
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CNV_R;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CNV_R: state_d = WAIT_R;
            WAIT_R: begin
                if (cnv_done) begin
                    right_d = a2d_res;
                    state_d = CNV_L;
                end
            end
            CNV_L: state_d = WAIT_L;
            WAIT_L: begin
                if (cnv_done) begin
                    accum_d = accum_q + wdiff;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (pair_q == 2'd2) begin
                    state_d = CALC;
                end else begin
                    pair_d  = pair_q + 2'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            CALC: begin
                lft_d   = lft_calc;
                rht_d   = rht_calc;
                done_d  = 1'b1;
                accum_d = '0;
                pair_d  = 2'd0;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            default: state_d = IDLE;
        endcase

        // Dropping go wins over everything, including a pending CALC.
        if (!go) begin
            state_d = IDLE;
            pair_d  = 2'd0;
            cnt_d   = '0;
            accum_d = '0;
            lft_d   = '0;
            rht_d   = '0;
            done_d  = 1'b0;
        end

        // Outputs decoded from the next state so they are registered.
        strt_d = (state_d == CNV_R) || (state_d == CNV_L);
        if (state_d == CNV_R) begin
            chnnl_d = rch(pair_d);
        end else if (state_d == CNV_L) begin
            chnnl_d = lch(pair_d);
        end else if (state_d == IDLE) begin
            chnnl_d = '0;
        end else begin
            chnnl_d = chnnl_q;
        end
        if (state_d inside {SETTLE, CNV_R, WAIT_R, CNV_L, WAIT_L}) begin
            en_d = 3'b001 << pair_d;
        end else begin
            en_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pair_q  <= '0;
            cnt_q   <= '0;
            accum_q <= '0;
            right_q <= '0;
            strt_q  <= 1'b0;
            chnnl_q <= '0;
            en_q    <= '0;
            lft_q   <= '0;
            rht_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            cnt_q   <= cnt_d;
            accum_q <= accum_d;
            right_q <= right_d;
            strt_q  <= strt_d;
            chnnl_q <= chnnl_d;
            en_q    <= en_d;
            lft_q   <= lft_d;
            rht_q   <= rht_d;
            done_q  <= done_d;
        end
    end

    assign strt_cnv   = strt_q;
    assign chnnl      = chnnl_q;
    assign IR_in_en   = en_q[0];
    assign IR_mid_en  = en_q[1];
    assign IR_out_en  = en_q[2];
    assign lft_duty   = lft_q;
    assign rht_duty   = rht_q;
    assign cycle_done = done_q;

endmodule

// File: tb/tb_ir_motion_seq.sv
// tb_ir_motion_seq: scoreboard bench for ir_motion_seq.
// Two instances (BASE_DUTY 1024 and 1900) share one A2D model.

module tb_ir_motion_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        cnv_done;
    logic [11:0] a2d_res;

    logic        strt1, done1, in1, mid1, out1;
    logic [2:0]  ch1;
    logic [10:0] lft1, rht1;
    logic        strt2, done2, in2, mid2, out2;
    logic [2:0]  ch2;
    logic [10:0] lft2, rht2;

    ir_motion_seq #(.SETTLE_CYC(8), .BASE_DUTY(1024), .GAIN_SHFT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .go(go),
        .cnv_done(cnv_done), .a2d_res(a2d_res),
        .strt_cnv(strt1), .chnnl(ch1),
        .IR_in_en(in1), .IR_mid_en(mid1), .IR_out_en(out1),
        .lft_duty(lft1), .rht_duty(rht1), .cycle_done(done1)
    );

    ir_motion_seq #(.SETTLE_CYC(8), .BASE_DUTY(1900), .GAIN_SHFT(2)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .go(go),
        .cnv_done(cnv_done), .a2d_res(a2d_res),
        .strt_cnv(strt2), .chnnl(ch2),
        .IR_in_en(in2), .IR_mid_en(mid2), .IR_out_en(out2),
        .lft_duty(lft2), .rht_duty(rht2), .cycle_done(done2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int l1;
        int r1;
        int l2;
        int r2;
    } exp_t;

    exp_t        exp_q[$];
    int          res_tab[8];
    int          a2d_lat = 3;
    int          n_tests = 0;
    int          n_fail = 0;
    int          ch_seen[$];
    logic [2:0]  en_seen[$];
    int          strt_cnt = 0;
    int          strt_long = 0;
    int          en_multi = 0;
    int          done_cnt = 0;
    int          duty_bad = 0;
    bit          mon_duty_en = 0;
    logic        sp = 1'b0;
    logic [43:0] pd = '0;

    // A2D model: answers each strt_cnv after a2d_lat cycles.
    initial begin : a2d_model
        int cd;
        int ch;
        cd = 0;
        ch = 0;
        cnv_done = 1'b0;
        a2d_res = '0;
        forever begin
            @(posedge clk);
            #1;
            cnv_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    a2d_res = 12'(res_tab[ch]);
                    cnv_done = 1'b1;
                end
            end else if (strt1) begin
                ch = int'(ch1);
                cd = a2d_lat - 1;
            end
        end
    end

    // Protocol monitor: only gathers observations.
    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (strt1) begin
                strt_cnt++;
                ch_seen.push_back(int'(ch1));
                en_seen.push_back({out1, mid1, in1});
                if (sp) strt_long++;
            end
            sp = strt1;
            if ($countones({out1, mid1, in1}) > 1) en_multi++;
            if (done1) done_cnt++;
            if (mon_duty_en && !done1 && ({lft1, rht1, lft2, rht2} != pd))
                duty_bad++;
            pd = {lft1, rht1, lft2, rht2};
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model(input int base, output int lf, output int rt);
        int acc;
        int sat;
        int err;
        acc = (res_tab[1] - res_tab[0])
            + 2 * (res_tab[4] - res_tab[2])
            + 4 * (res_tab[3] - res_tab[7]);
        sat = clamp(acc, -2048, 2047);
        err = sat >>> 2;
        lf = clamp(base + err, 0, 2047);
        rt = clamp(base - err, 0, 2047);
    endfunction

    task automatic set_case(input int k);
        for (int i = 0; i < 8; i++) res_tab[i] = 2048;
        case (k)
            1: res_tab[1] = 2304;
            2: begin res_tab[3] = 4095; res_tab[7] = 0; end
            3: begin res_tab[2] = 4095; res_tab[4] = 0; end
            4: res_tab[0] = 2051;
            default: ;
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        int a, b;
        model(1024, a, b);
        e.l1 = a;
        e.r1 = b;
        model(1900, a, b);
        e.l2 = a;
        e.r2 = b;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        ch_seen.delete();
        en_seen.delete();
        strt_long = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (done1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_strt(input int ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (strt1 && int'(ch1) == ch) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        set_case(0);
        a2d_lat = 3;
        go = 1'b1;
        rst_n = 1'b0;
        cyc(2);
        n_tests++;
        if ({strt1, ch1, in1, mid1, out1, lft1, rht1, done1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs dut1 got %h want 0",
                     {strt1, ch1, in1, mid1, out1, lft1, rht1, done1});
        end
        n_tests++;
        if ({strt2, ch2, in2, mid2, out2, lft2, rht2, done2} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs dut2 got %h want 0",
                     {strt2, ch2, in2, mid2, out2, lft2, rht2, done2});
        end
        rst_n = 1'b1;
        cyc(1);
        n_tests++;
        if ({in1, mid1, out1, strt1} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_settle got %b want 1000", {in1, mid1, out1, strt1});
        end
        go = 1'b0;
        cyc(1);
        n_tests++;
        if ({in1, mid1, out1} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_go_low en got %b want 000", {in1, mid1, out1});
        end
    endtask

    task automatic test_equal();
        bit ok;
        exp_t e;
        int xch[6] = '{1, 0, 4, 2, 3, 7};
        logic [2:0] xen[6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
        logic [17:0] gch, wch, gen, wen;
        set_case(0);
        clear_mon();
        push_exp();
        go = 1'b1;
        wait_done(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL equal_timeout got no cycle_done want pulse");
        end
        e = exp_q.pop_front();
        n_tests++;
        if ({lft1, rht1, lft2, rht2} !== {11'(e.l1), 11'(e.r1), 11'(e.l2), 11'(e.r2)}) begin
            n_fail++;
            $display("FAIL equal_duty got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     lft1, rht1, lft2, rht2, e.l1, e.r1, e.l2, e.r2);
        end
        go = 1'b0;
        cyc(2);
        n_tests++;
        if (ch_seen.size() != 6) begin
            n_fail++;
            $display("FAIL equal_nstrt got %0d want 6", ch_seen.size());
        end
        gch = '0; wch = '0; gen = '0; wen = '0;
        for (int i = 0; i < 6; i++) begin
            wch = {wch[14:0], 3'(xch[i])};
            wen = {wen[14:0], xen[i]};
            if (i < ch_seen.size()) begin
                gch = {gch[14:0], 3'(ch_seen[i])};
                gen = {gen[14:0], en_seen[i]};
            end
        end
        n_tests++;
        if (gch !== wch) begin
            n_fail++;
            $display("FAIL equal_chnnl got %o want %o", gch, wch);
        end
        n_tests++;
        if (gen !== wen) begin
            n_fail++;
            $display("FAIL equal_enables got %o want %o", gen, wen);
        end
        n_tests++;
        if (strt_long != 0) begin
            n_fail++;
            $display("FAIL equal_strt_width got %0d long want 0", strt_long);
        end
        n_tests++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL equal_done_cnt got %0d want 1", done_cnt);
        end
        n_tests++;
        if ({lft1, rht1, in1} !== '0) begin
            n_fail++;
            $display("FAIL equal_idle got %0d/%0d en %b want 0", lft1, rht1, in1);
        end
    endtask

    task automatic test_steer();
        bit ok;
        exp_t e;
        int ks[3] = '{1, 2, 3};
        foreach (ks[j]) begin
            set_case(ks[j]);
            clear_mon();
            push_exp();
            go = 1'b1;
            wait_done(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL steer%0d_timeout got no cycle_done want pulse", ks[j]);
            end
            e = exp_q.pop_front();
            n_tests++;
            if ({lft1, rht1, lft2, rht2} !== {11'(e.l1), 11'(e.r1), 11'(e.l2), 11'(e.r2)}) begin
                n_fail++;
                $display("FAIL steer%0d_duty got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                         ks[j], lft1, rht1, lft2, rht2, e.l1, e.r1, e.l2, e.r2);
            end
            go = 1'b0;
            cyc(2);
        end
    endtask

    task automatic test_abort();
        bit ok;
        exp_t e;
        int s0, d0;
        a2d_lat = 5;
        set_case(1);
        clear_mon();
        push_exp();
        go = 1'b1;
        wait_done(ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || {lft1, rht1} !== {11'(e.l1), 11'(e.r1)}) begin
            n_fail++;
            $display("FAIL abort_pre_duty got %0d/%0d want %0d/%0d", lft1, rht1, e.l1, e.r1);
        end
        wait_strt(2, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL abort_find_wait_l got no chnnl 2 strt want one");
        end
        cyc(1);
        go = 1'b0;
        cyc(1);
        n_tests++;
        if ({in1, mid1, out1, strt1, lft1, rht1} !== '0) begin
            n_fail++;
            $display("FAIL abort_idle1 got en %b strt %b duty %0d/%0d want 0",
                     {out1, mid1, in1}, strt1, lft1, rht1);
        end
        n_tests++;
        if ({in2, mid2, out2, strt2, lft2, rht2} !== '0) begin
            n_fail++;
            $display("FAIL abort_idle2 got en %b duty %0d/%0d want 0",
                     {out2, mid2, in2}, lft2, rht2);
        end
        s0 = strt_cnt;
        d0 = done_cnt;
        cyc(6);
        n_tests++;
        if (strt_cnt != s0 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL abort_quiet got strt +%0d done +%0d want 0/0",
                     strt_cnt - s0, done_cnt - d0);
        end
        n_tests++;
        if ({in1, mid1, out1, lft1, rht1} !== '0) begin
            n_fail++;
            $display("FAIL abort_late_pulse got en %b duty %0d/%0d want 0",
                     {out1, mid1, in1}, lft1, rht1);
        end
        a2d_lat = 3;
        set_case(0);
        clear_mon();
        push_exp();
        go = 1'b1;
        wait_done(ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || {lft1, rht1, lft2, rht2} !== {11'(e.l1), 11'(e.r1), 11'(e.l2), 11'(e.r2)}) begin
            n_fail++;
            $display("FAIL abort_restart_duty got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     lft1, rht1, lft2, rht2, e.l1, e.r1, e.l2, e.r2);
        end
        n_tests++;
        if (ch_seen.size() == 0 || ch_seen[0] != 1) begin
            n_fail++;
            $display("FAIL abort_restart_chnnl got %0d want 1",
                     (ch_seen.size() == 0) ? -1 : ch_seen[0]);
        end
        go = 1'b0;
        cyc(2);
    endtask

    task automatic test_mid_reset();
        bit ok;
        exp_t e;
        set_case(1);
        clear_mon();
        push_exp();
        go = 1'b1;
        wait_done(ok);
        e = exp_q.pop_front();
        wait_strt(4, ok);
        rst_n = 1'b0;
        cyc(1);
        n_tests++;
        if (!ok || {strt1, in1, mid1, out1, lft1, rht1, done1} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outs got en %b duty %0d/%0d want 0",
                     {out1, mid1, in1}, lft1, rht1);
        end
        rst_n = 1'b1;
        clear_mon();
        push_exp();
        wait_done(ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || {lft1, rht1, lft2, rht2} !== {11'(e.l1), 11'(e.r1), 11'(e.l2), 11'(e.r2)}) begin
            n_fail++;
            $display("FAIL midreset_duty got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     lft1, rht1, lft2, rht2, e.l1, e.r1, e.l2, e.r2);
        end
        go = 1'b0;
        cyc(2);
    endtask

    task automatic test_back_to_back();
        bit ok;
        exp_t e;
        int ks[3] = '{4, 1, 3};
        clear_mon();
        duty_bad = 0;
        mon_duty_en = 1'b1;
        set_case(ks[0]);
        push_exp();
        go = 1'b1;
        for (int p = 0; p < 3; p++) begin
            wait_done(ok);
            e = exp_q.pop_front();
            n_tests++;
            if (!ok || {lft1, rht1, lft2, rht2} !== {11'(e.l1), 11'(e.r1), 11'(e.l2), 11'(e.r2)}) begin
                n_fail++;
                $display("FAIL b2b_pass%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                         p, lft1, rht1, lft2, rht2, e.l1, e.r1, e.l2, e.r2);
            end
            if (p < 2) begin
                set_case(ks[p + 1]);
                push_exp();
            end
        end
        go = 1'b0;
        mon_duty_en = 1'b0;
        cyc(2);
        n_tests++;
        if (done_cnt != 3) begin
            n_fail++;
            $display("FAIL b2b_done_cnt got %0d want 3", done_cnt);
        end
        n_tests++;
        if (duty_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_duty_stable got %0d changes want 0", duty_bad);
        end
        n_tests++;
        if (ch_seen.size() != 18 || strt_long != 0) begin
            n_fail++;
            $display("FAIL b2b_strt got %0d pulses %0d long want 18/0",
                     ch_seen.size(), strt_long);
        end
        n_tests++;
        if (en_multi != 0) begin
            n_fail++;
            $display("FAIL onehot_enables got %0d overlaps want 0", en_multi);
        end
    endtask

    initial begin : main
        test_reset();
        test_equal();
        test_steer();
        test_abort();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
